// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter.
//   SEG_BLANK / SEG_DASH : active-low segment patterns {g,f,e,d,c,b,a}
//   state_t              : arbiter FSM states
//   MP_*                 : multi-request policy encodings
//   cnt_w()              : counter width for a modulus (minimum 1 bit)
package seg_display_arbiter_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int MP_ERROR   = 0;
  localparam int MP_HIGHEST = 1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bundle between the animation generators / switches and the arbiter, and
// between the arbiter and the display pins.
//   en_sw, mode_req : raw switch inputs (asynchronous)
//   frame_in        : flattened frames, frame m digit d at [(m*NUM_DIGITS+d)*7 +: 7]
//   segmentos       : active-low segments
//   anodos          : active-low anodes
//   active_frame    : frame currently shown
//   err             : error state flag
//   frame_tick      : one-cycle pulse on digit-index wrap
// master drives the inputs (source side), slave is the arbiter.
interface seg_display_arbiter_if
  import seg_display_arbiter_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_MODES  = 3
);
  localparam int SW = cnt_w(NUM_MODES + 1);

  logic                                  en_sw;
  logic [NUM_MODES-1:0]                  mode_req;
  logic [(NUM_MODES+1)*NUM_DIGITS*7-1:0] frame_in;
  logic [6:0]                            segmentos;
  logic [NUM_DIGITS-1:0]                 anodos;
  logic [SW-1:0]                         active_frame;
  logic                                  err;
  logic                                  frame_tick;

  modport master (
    output en_sw, mode_req, frame_in,
    input  segmentos, anodos, active_frame, err, frame_tick
  );

  modport slave (
    input  en_sw, mode_req, frame_in,
    output segmentos, anodos, active_frame, err, frame_tick
  );
endinterface

// File: rtl/seg_display_arbiter_sw_sync_debounce.sv
// 2-FF synchroniser plus stability debounce for a vector of switches.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_async     : raw asynchronous inputs
//   o_accepted  : debounced vector; follows the synchronised vector once it
//                 has been stable for DEBOUNCE_CYC cycles (0 = bypass)
module sw_sync_debounce #(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_accepted
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign o_accepted = r_sync;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYC + 1);

      logic [CW-1:0]    r_cnt;
      logic [WIDTH-1:0] r_acc;

      // Reload is keyed on r_meta != r_sync, i.e. on the same edge at which
      // the synchronised vector changes, giving 2+DEBOUNCE_CYC worst case.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else if (r_meta != r_sync) begin
          r_cnt <= CW'(DEBOUNCE_CYC);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_acc <= r_sync;
        end
      end

      assign o_accepted = r_acc;
    end
  endgenerate

endmodule

// File: rtl/seg_display_arbiter.sv
// Selects one of NUM_MODES+1 frames from the switch inputs and scans it onto
// NUM_DIGITS multiplexed 7-segment digits, with a blanking interval on every
// mode change and a blinking dash frame on conflicting requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   disp       : seg_display_arbiter_if.slave (switches, frames, pins, status)
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int NUM_MODES        = 3,
  parameter int SCAN_DIV         = 100000,
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int BLANK_FRAMES     = 4,
  parameter int ERR_BLINK_FRAMES = 32,
  parameter int MULTI_POLICY     = MP_ERROR
) (
  input logic                  clk,
  input logic                  rst_n,
  seg_display_arbiter_if.slave disp
);

  localparam int SW = cnt_w(NUM_MODES + 1);
  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int PW = cnt_w(SCAN_DIV);
  localparam int BW = cnt_w(BLANK_FRAMES);
  localparam int EW = cnt_w(ERR_BLINK_FRAMES);

  // Input conditioning: bit 0 = enable, bits [NUM_MODES:1] = mode requests.
  logic [NUM_MODES:0]   w_acc;
  logic                 w_en;
  logic [NUM_MODES-1:0] w_mode;

  sw_sync_debounce #(
    .WIDTH       (NUM_MODES + 1),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_async   ({disp.mode_req, disp.en_sw}),
    .o_accepted(w_acc)
  );

  assign w_en   = w_acc[0];
  assign w_mode = w_acc[NUM_MODES:1];

  // Selection: w_sel ends as highest set bit + 1; w_many flags >1 request.
  logic [SW-1:0] w_sel;
  logic          w_many;
  logic          w_multi;

  always_comb begin
    w_sel  = '0;
    w_many = 1'b0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (w_mode[i]) begin
        if (w_sel != '0) w_many = 1'b1;
        w_sel = SW'(i + 1);
      end
    end
  end

  assign w_multi = w_many && (MULTI_POLICY != MP_HIGHEST);

  // Scan timing
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic          r_frame_tick;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = (r_pre == PW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else if (r_state == ST_OFF) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (w_tick) begin
        r_pre <= '0;
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // FSM
  logic [SW-1:0] r_target;
  logic [SW-1:0] r_active;
  logic [BW-1:0] r_bcnt;
  logic [EW-1:0] r_blink;
  logic          r_blink_on;
  logic          w_capture;
  logic          w_bcnt_inc;
  logic          w_load_active;
  logic          w_err_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_bcnt_inc    = 1'b0;
    w_load_active = 1'b0;
    w_err_entry   = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (w_en) begin
          w_state_nxt = ST_BLANK;
          w_capture   = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!w_en) begin
          w_state_nxt = ST_OFF;
        end else if (w_sel != r_target) begin
          w_capture = 1'b1;
        end else if (w_wrap) begin
          if (r_bcnt == BW'(BLANK_FRAMES - 1)) begin
            if (w_multi) begin
              w_state_nxt = ST_ERROR;
              w_err_entry = 1'b1;
            end else begin
              w_state_nxt   = ST_SHOW;
              w_load_active = 1'b1;
            end
          end else begin
            w_bcnt_inc = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        if (!w_en) begin
          w_state_nxt = ST_OFF;
        end else if (w_multi || (w_sel != r_active)) begin
          w_state_nxt = ST_BLANK;
          w_capture   = 1'b1;
        end
      end
      ST_ERROR: begin
        if (!w_en) begin
          w_state_nxt = ST_OFF;
        end else if (!w_multi) begin
          w_state_nxt = ST_BLANK;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= '0;
      r_active   <= '0;
      r_bcnt     <= '0;
      r_blink    <= '0;
      r_blink_on <= 1'b0;
    end else begin
      if (w_capture)       r_bcnt <= '0;
      else if (w_bcnt_inc) r_bcnt <= r_bcnt + 1'b1;
      if (w_capture)       r_target <= w_sel;
      if (w_load_active)   r_active <= r_target;
      if (w_err_entry) begin
        r_blink    <= '0;
        r_blink_on <= 1'b1;
      end else if ((r_state == ST_ERROR) && w_wrap) begin
        if (r_blink == EW'(ERR_BLINK_FRAMES - 1)) begin
          r_blink    <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_blink <= r_blink + 1'b1;
        end
      end
    end
  end

  // Output registration (one cycle behind the digit index)
  logic [NUM_MODES:0][NUM_DIGITS-1:0][6:0] w_frames;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  assign w_frames = disp.frame_in;

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = '1;
    case (r_state)
      ST_SHOW: begin
        w_seg_nxt = w_frames[r_active][r_idx];
        w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
      end
      ST_ERROR: begin
        if (r_blink_on) begin
          w_seg_nxt = SEG_DASH;
          w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign disp.segmentos    = r_seg;
  assign disp.anodos       = r_an;
  assign disp.active_frame = r_active;
  assign disp.err          = (r_state == ST_ERROR);
  assign disp.frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench: two arbiters (policy 0 and policy 1) share one stimulus.
module tb_seg_display_arbiter;

  localparam int ND  = 8;
  localparam int NM  = 3;
  localparam int SD  = 4;
  localparam int FW  = (NM + 1) * ND * 7;

  logic          clk;
  logic          rst_n;
  logic          en_sw;
  logic [NM-1:0] mode_req;
  logic [FW-1:0] frame_in;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  seg_display_arbiter_if #(.NUM_DIGITS(ND), .NUM_MODES(NM)) bus0 ();
  seg_display_arbiter_if #(.NUM_DIGITS(ND), .NUM_MODES(NM)) bus1 ();

  assign bus0.en_sw    = en_sw;
  assign bus0.mode_req = mode_req;
  assign bus0.frame_in = frame_in;
  assign bus1.en_sw    = en_sw;
  assign bus1.mode_req = mode_req;
  assign bus1.frame_in = frame_in;

  seg_display_arbiter #(
    .NUM_DIGITS(ND), .NUM_MODES(NM), .SCAN_DIV(SD), .DEBOUNCE_CYC(3),
    .BLANK_FRAMES(1), .ERR_BLINK_FRAMES(2), .MULTI_POLICY(0)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .disp (bus0)
  );

  seg_display_arbiter #(
    .NUM_DIGITS(ND), .NUM_MODES(NM), .SCAN_DIV(SD), .DEBOUNCE_CYC(3),
    .BLANK_FRAMES(1), .ERR_BLINK_FRAMES(2), .MULTI_POLICY(1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .disp (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int m, input int d);
    return 7'(m * 16 + d + 1);
  endfunction

  task automatic wait_act(input bit which, input logic [1:0] f, input int unsigned lim);
    int unsigned k = 0;
    logic [1:0] cur;
    cur = which ? bus1.active_frame : bus0.active_frame;
    while (cur !== f && k < lim) begin
      @(negedge clk);
      k++;
      cur = which ? bus1.active_frame : bus0.active_frame;
    end
    if (cur !== f) chk("wait_active", 32'(cur), 32'(f));
  endtask

  // Entered at the negedge right after the wrap that starts frame m.
  task automatic check_walk(input string tag, input int m);
    logic [7:0] an_exp;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      if (d != 0) repeat (SD) @(negedge clk);
      an_exp = ~(8'(1) << d);
      chk({tag, "_an"}, 32'(bus0.anodos), 32'(an_exp));
      chk({tag, "_seg"}, 32'(bus0.segmentos), 32'(pat(m, d)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n    = 1'b1;
    en_sw    = 1'b0;
    mode_req = '0;
    frame_in = '0;
    for (int m = 0; m <= NM; m++)
      for (int d = 0; d < ND; d++)
        frame_in[(m * ND + d) * 7 +: 7] = pat(m, d);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_seg", 32'(bus0.segmentos), 32'h7F);
    chk("rst_an", 32'(bus0.anodos), 32'hFF);
    chk("rst_act", 32'(bus0.active_frame), 32'h0);
    chk("rst_err", 32'(bus0.err), 32'h0);
    chk("rst_ft", 32'(bus0.frame_tick), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Enable, base frame: accepted at edge 5, BLANK at 6, first wrap at 38
    en_sw = 1'b1;
    repeat (37) @(negedge clk);
    chk("blank_an_e37", 32'(bus0.anodos), 32'hFF);
    chk("blank_ft_e37", 32'(bus0.frame_tick), 32'h0);
    @(negedge clk);
    chk("blank_an_e38", 32'(bus0.anodos), 32'hFF);
    chk("wrap_ft_e38", 32'(bus0.frame_tick), 32'h1);
    check_walk("f0", 0);
    chk("f0_ft_low", 32'(bus0.frame_tick), 32'h0);

    // Switch to mode 2
    mode_req = 3'b010;
    repeat (7) @(negedge clk);
    chk("m2_blank_an", 32'(bus0.anodos), 32'hFF);
    chk("m2_blank_seg", 32'(bus0.segmentos), 32'h7F);
    wait_act(1'b0, 2'd2, 200);
    check_walk("f2", 2);

    // Two requests: policy 0 -> error, policy 1 -> highest (frame 3)
    mode_req = 3'b101;
    wait_act(1'b1, 2'd3, 200);
    chk("multi_err0", 32'(bus0.err), 32'h1);
    chk("multi_err1", 32'(bus1.err), 32'h0);
    @(negedge clk);
    chk("err_w1_seg", 32'(bus0.segmentos), 32'h3F);
    chk("err_w1_an", 32'(bus0.anodos), 32'hFE);
    chk("p1_w1_an", 32'(bus1.anodos), 32'hFE);
    chk("p1_w1_seg", 32'(bus1.segmentos), 32'(pat(3, 0)));
    repeat (12) @(negedge clk);
    chk("err_w13_an", 32'(bus0.anodos), 32'hF7);
    chk("err_w13_seg", 32'(bus0.segmentos), 32'h3F);
    repeat (51) @(negedge clk);
    chk("err_w64_an", 32'(bus0.anodos), 32'h7F);
    chk("err_w64_seg", 32'(bus0.segmentos), 32'h3F);
    @(negedge clk);
    chk("err_off_seg", 32'(bus0.segmentos), 32'h7F);
    chk("err_off_an", 32'(bus0.anodos), 32'hFF);
    chk("err_off_err", 32'(bus0.err), 32'h1);
    repeat (63) @(negedge clk);
    chk("err_w128_an", 32'(bus0.anodos), 32'hFF);
    @(negedge clk);
    chk("err_on2_seg", 32'(bus0.segmentos), 32'h3F);
    chk("err_on2_an", 32'(bus0.anodos), 32'hFE);

    // Clear conflict
    mode_req = 3'b010;
    wait_act(1'b1, 2'd2, 200);
    chk("clr_act0", 32'(bus0.active_frame), 32'h2);
    chk("clr_err0", 32'(bus0.err), 32'h0);

    // Short pulse on mode_req[0] is rejected by the debounce
    mode_req = 3'b011;
    repeat (2) @(negedge clk);
    mode_req = 3'b010;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus0.anodos == 8'hFF || bus0.active_frame != 2'd2 || bus0.err) bad++;
    end
    chk("glitch_bad", 32'(bad), 32'h0);
    chk("glitch_act", 32'(bus0.active_frame), 32'h2);

    // Asynchronous reset mid-SHOW
    rst_n = 1'b0;
    #1;
    chk("mrst_seg", 32'(bus0.segmentos), 32'h7F);
    chk("mrst_an", 32'(bus0.anodos), 32'hFF);
    chk("mrst_err", 32'(bus0.err), 32'h0);
    chk("mrst_act", 32'(bus0.active_frame), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_an", 32'(bus0.anodos), 32'hFF);
    chk("post_rst_ft", 32'(bus0.frame_tick), 32'h0);

    // en still high: BLANK from edge 6; drop en at edge 10 -> OFF at edge 16
    repeat (9) @(negedge clk);
    chk("blank2_an", 32'(bus0.anodos), 32'hFF);
    en_sw = 1'b0;
    repeat (7) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus0.frame_tick || bus0.anodos != 8'hFF || bus0.segmentos != 7'h7F) bad++;
    end
    chk("off_bad", 32'(bad), 32'h0);
    chk("off_act", 32'(bus0.active_frame), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Parametrised single-clock successor to the top-level 7-segment source selector.
- Arbitrates between one base frame and NUM_MODES animation frames supplied as flattened digit buffers, then scans the selected frame onto NUM_DIGITS multiplexed digits.
- Adds input synchronisation, debounce, a blanking interval on mode change, a blinking error frame, and selectable multi-request policy.
- Replaces derived clocks with clock-enable ticks; sits between the animation generators and the board pins.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits/anodes (2..16).
- NUM_MODES, 3: animation modes; frame 0 is the base frame, frames 1..NUM_MODES are the animations.
- SCAN_DIV, 100000: clk cycles per digit-scan tick (>=2).
- DEBOUNCE_CYC, 1000000: clk cycles the synchronised inputs must stay stable before being accepted; 0 bypasses debounce.
- BLANK_FRAMES, 4: full scan frames blanked on entry to display and on every mode change (>=1).
- ERR_BLINK_FRAMES, 32: frames per on/off half-period of the error frame.
- MULTI_POLICY, 0: 0 = more than one request is an error; 1 = highest requested index wins.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en_sw, input, 1: display on/off switch (asynchronous source).
- mode_req, input, NUM_MODES: animation request switches (asynchronous source).
- frame_in, input, (NUM_MODES+1)*NUM_DIGITS*7: frame m, digit d at bits [(m*NUM_DIGITS+d)*7 +: 7]; active-low, bit order {g,f,e,d,c,b,a}.
- segmentos, output, 7: active-low segments, registered.
- anodos, output, NUM_DIGITS: active-low anodes, registered, at most one low.
- active_frame, output, clog2(NUM_MODES+1): frame currently displayed.
- err, output, 1: high while in the ERROR state.
- frame_tick, output, 1: one-cycle pulse on digit-index wrap.

Behaviour:
- Reset (async, rst_n low): segmentos=7'h7F, anodos all 1, active_frame=0, err=0, frame_tick=0, state=OFF; all counters and synchronisers cleared.
- Synchronisation: 2-FF synchroniser on {en_sw, mode_req}. Debounce counter reloads on any change of the synchronised vector; the accepted vector updates when the counter expires. Worst-case input-to-accept latency is 2+DEBOUNCE_CYC cycles.
- Selection (combinational on the accepted vector):
  - zero requests: sel=0.
  - exactly one request at bit i: sel=i+1.
  - more than one request: multi=1 if MULTI_POLICY=0; otherwise sel = highest set bit + 1.
- Scan:
  - Prescaler runs only outside OFF and produces tick every SCAN_DIV cycles.
  - Digit index increments on tick and wraps NUM_DIGITS-1 -> 0; the wrap raises frame_tick.
  - Outputs are registered one cycle after the index update; anodos bit[idx]=0.
- FSM:
  - OFF: outputs blank; prescaler and index held at 0. Moves to BLANK when accepted en=1.
  - BLANK: outputs blank with the scan running; the latched target sel is captured on entry. After BLANK_FRAMES frame_ticks, moves to ERROR if multi, else SHOW with active_frame=target.
  - SHOW: drives frame_in[active_frame][idx]. A change in accepted sel moves to BLANK; multi moves to BLANK, which then resolves to ERROR.
  - ERROR: err=1. Every digit shows 7'b0111111 (dash) during the on half-period and blank during the off half-period; the blink counter counts frame_ticks. When multi clears, moves to BLANK.
- Accepted en=0 in any state moves to OFF on the next cycle and blanks outputs on the following cycle.
- A sel change during BLANK re-captures the target and restarts the blank count.
- Mid-operation reset returns to OFF immediately (async).
- frame_in may change at any time; it is sampled per digit at output registration.

Decomposition:
- Shared package: segment constants (SEG_BLANK=7'h7F, SEG_DASH=7'h3F), the state encoding (OFF, BLANK, SHOW, ERROR), and the MULTI_POLICY encodings.
- One sub-module: sw_sync_debounce, parametrised by width and DEBOUNCE_CYC. It holds the 2-FF synchroniser, the stability counter and the accepted register, and is instantiated once for the (NUM_MODES+1)-bit vector.

Test Plan (defaults except SCAN_DIV=4, DEBOUNCE_CYC=3, BLANK_FRAMES=1, ERR_BLINK_FRAMES=2):
- Assert rst_n low mid-SHOW -> segmentos=7'h7F, anodos=8'hFF, err=0 in the same cycle; state OFF after release.
- en_sw=1, mode_req=0, frame 0 digits distinct -> blank for 32 cycles, then anodos walks FE, FD, ... 7F; segmentos equals frame 0 digit idx one cycle after each tick.
- In SHOW, set mode_req=3'b010 -> blank frame inserted, then active_frame=2 showing frame 2 data.
- mode_req=3'b101 with MULTI_POLICY=0 -> err=1 and dashes alternating 2 frames on / 2 frames off; with MULTI_POLICY=1 -> active_frame=3, err=0.
- Pulse mode_req[0] for 2 cycles (shorter than debounce) -> no state change and active_frame unchanged.
- Drop en_sw during BLANK -> OFF; outputs all ones, prescaler frozen, frame_tick stays 0.
